apb_fifo_slave: RTL

APB slave peripheral bridging the APB bus to a pair of streaming FIFOs. It sits downstream of the APB master bridge, on one PSEL line, alongside the existing register slaves. APB writes push words into a TX FIFO that drains onto a valid/ready output stream. An input stream fills an RX FIFO that APB reads pop.

---
 rtl/apb_fifo_pkg.sv | 26 ++
 rtl/apb_fifo_slave_sync_fifo.sv | 60 ++++++
 rtl/apb_fifo_slave.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/apb_fifo_pkg.sv
// Shared definitions for the APB FIFO slave: register offsets, STATUS/CTRL
// bit positions and the APB handshake state encoding.
package apb_fifo_pkg;

  localparam logic [7:0] TXDATA = 8'h00;
  localparam logic [7:0] RXDATA = 8'h04;
  localparam logic [7:0] STATUS = 8'h08;
  localparam logic [7:0] CTRL   = 8'h0C;

  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_TX_COUNT = 8;
  localparam int ST_RX_COUNT = 16;

  localparam int CTRL_FLUSH_TX = 0;
  localparam int CTRL_FLUSH_RX = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_fifo_slave_sync_fifo.sv
// Single-clock FIFO with push, pop, flush and an occupancy count. Flush has
// priority over any push/pop on the same edge; overflow and underflow are ignored.
module sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_pushData,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [CW-1:0]     o_count
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wrPtr;
  logic [AW-1:0]     r_rdPtr;
  logic [CW-1:0]     r_count;
  logic              w_doPush;
  logic              w_doPop;

  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_data   = r_mem[r_rdPtr];
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  // Pointers are exactly log2(DEPTH) wide so they wrap modulo DEPTH by themselves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush && !i_flush) r_mem[r_wrPtr] <= i_pushData;
  end

endmodule

// File: rtl/apb_fifo_slave.sv
// APB slave bridging register accesses to a TX and an RX streaming FIFO.
// Define APB_FIFO_WAIT_EN to stall full-push/empty-pop accesses up to MAX_WAIT cycles.
module apb_fifo_slave
  import apb_fifo_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  apb_state_e        r_state;
  logic [7:0]        w_offset;
  logic              w_aligned;
  logic              w_isTx;
  logic              w_isRx;
  logic              w_isStatus;
  logic              w_isCtrl;
  logic              w_txWrite;
  logic              w_rxRead;
  logic              w_stall;
  logic              w_decodeErr;
  logic              w_accessPhase;
  logic              w_ready;
  logic              w_slverr;
  logic              w_ok;
  logic              w_txPush;
  logic              w_rxPop;
  logic              w_txFlush;
  logic              w_rxFlush;
  logic              w_txFull;
  logic              w_txEmpty;
  logic              w_rxFull;
  logic              w_rxEmpty;
  logic [CNT_W-1:0]  w_txCount;
  logic [CNT_W-1:0]  w_rxCount;
  logic [DATA_W-1:0] w_rxHead;
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_rdata;
  logic              w_unused;

  assign w_offset   = PADDR[7:0];
  assign w_aligned  = (PADDR[1:0] == 2'b00);
  assign w_isTx     = w_aligned && (w_offset == TXDATA);
  assign w_isRx     = w_aligned && (w_offset == RXDATA);
  assign w_isStatus = w_aligned && (w_offset == STATUS);
  assign w_isCtrl   = w_aligned && (w_offset == CTRL);
  assign w_txWrite  = w_isTx && PWRITE;
  assign w_rxRead   = w_isRx && !PWRITE;

  assign w_decodeErr = !(w_isTx || w_isRx || w_isStatus || w_isCtrl)
                    || (w_isTx && !PWRITE)
                    || (w_isRx && PWRITE)
                    || (w_isStatus && PWRITE);

  // Full/empty come straight from FIFO registers, so a same-edge stream
  // transfer cannot rescue an APB push into a full TX or pop from an empty RX.
  assign w_stall = (w_txWrite && w_txFull) || (w_rxRead && w_rxEmpty);

  // The state register lags the bus by a cycle: SETUP marks the first access cycle.
  assign w_accessPhase = PSEL && PENABLE && ((r_state == SETUP) || (r_state == ACCESS));

`ifdef APB_FIFO_WAIT_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] r_waitCnt;

  assign w_ready = w_accessPhase && (!w_stall || (r_waitCnt == WAIT_W'(MAX_WAIT)));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_waitCnt <= '0;
    end else if (w_accessPhase && !w_ready) begin
      r_waitCnt <= r_waitCnt + WAIT_W'(1);
    end else begin
      r_waitCnt <= '0;
    end
  end

  assign w_unused = ^PADDR[31:8];
`else
  assign w_ready  = w_accessPhase;
  assign w_unused = (^PADDR[31:8]) ^ (MAX_WAIT > 0);
`endif

  assign w_slverr  = w_ready && (w_decodeErr || w_stall);
  assign w_ok      = w_ready && !w_slverr;
  assign w_txPush  = w_ok && w_txWrite;
  assign w_rxPop   = w_ok && w_rxRead;
  assign w_txFlush = w_ok && w_isCtrl && PWRITE && PWDATA[CTRL_FLUSH_TX];
  assign w_rxFlush = w_ok && w_isCtrl && PWRITE && PWDATA[CTRL_FLUSH_RX];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
    end else if (!PSEL) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (!PENABLE) r_state <= SETUP;
        SETUP:   r_state <= w_ready ? IDLE : ACCESS;
        ACCESS:  if (w_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_txFifo (
    .clk        (PCLK),
    .rst_n      (PRESETn),
    .i_push     (w_txPush),
    .i_pushData (PWDATA),
    .i_pop      (tx_valid && tx_ready),
    .i_flush    (w_txFlush),
    .o_data     (tx_data),
    .o_full     (w_txFull),
    .o_empty    (w_txEmpty),
    .o_count    (w_txCount)
  );

  sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_rxFifo (
    .clk        (PCLK),
    .rst_n      (PRESETn),
    .i_push     (rx_valid && rx_ready),
    .i_pushData (rx_data),
    .i_pop      (w_rxPop),
    .i_flush    (w_rxFlush),
    .o_data     (w_rxHead),
    .o_full     (w_rxFull),
    .o_empty    (w_rxEmpty),
    .o_count    (w_rxCount)
  );

  assign tx_valid = !w_txEmpty;
  assign rx_ready = !w_rxFull;

  always_comb begin
    w_status = '0;
    w_status[ST_TX_EMPTY] = w_txEmpty;
    w_status[ST_TX_FULL]  = w_txFull;
    w_status[ST_RX_EMPTY] = w_rxEmpty;
    w_status[ST_RX_FULL]  = w_rxFull;
    w_status[ST_TX_COUNT +: CNT_W] = w_txCount;
    w_status[ST_RX_COUNT +: CNT_W] = w_rxCount;
  end

  // Read data is driven only for a successful read completing this cycle.
  always_comb begin
    w_rdata = '0;
    if (w_ok && !PWRITE) begin
      if (w_isRx)          w_rdata = w_rxHead;
      else if (w_isStatus) w_rdata = w_status;
    end
  end

  assign PRDATA  = w_rdata;
  assign PREADY  = w_ready;
  assign PSLVERR = w_slverr;

endmodule
